// File: rtl/stopwatch_lap_if.sv
// stopwatch_lap_if -- control and display bundle for the BCD stopwatch.
//   master modport: the controller side (drives start/stop/clear/load/
//                   count_down/preset_bcd/lap, observes the outputs).
//   slave modport : the stopwatch itself.
//   DIGITS        : number of BCD digits carried on the count buses.
interface stopwatch_lap_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  load;
    logic                  count_down;
    logic [4*DIGITS-1:0]   preset_bcd;
    logic                  lap;
    logic                  running;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [4*DIGITS-1:0]   display_bcd;
    logic                  lap_held;
    logic                  tick;
    logic                  wrap;
    logic                  expired;

    modport master (
        output start, stop, clear, load, count_down, preset_bcd, lap,
        input  running, count_bcd, display_bcd, lap_held, tick, wrap, expired
    );

    modport slave (
        input  start, stop, clear, load, count_down, preset_bcd, lap,
        output running, count_bcd, display_bcd, lap_held, tick, wrap, expired
    );
endinterface

// File: rtl/stopwatch_lap.sv
// stopwatch_lap -- parametrised BCD stopwatch / countdown timer with lap hold.
//   clk     : system clock, all state changes on rising edge
//   reset_n : asynchronous active-low reset (release synchronised inside)
//   sw      : stopwatch_lap_if.slave -- start/stop/clear/load pulses, mode,
//             preset, lap toggle; running/count/display/lap_held/tick/wrap/
//             expired outputs, all registered.
//   CLK_DIV : clk cycles per least-significant-digit step (>= 2)
//   DIGITS  : number of BCD digits (2..8), digit 0 least significant
module stopwatch_lap #(
    parameter int CLK_DIV = 260000,
    parameter int DIGITS  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_lap_if.slave   sw
);
    localparam int            PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    typedef logic [DIGITS-1:0][3:0] bcd_t;

    // Assert immediately, release two edges after reset_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    logic          running_q, running_d;
    logic          down_q, down_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_t          cnt_q, cnt_d;
    bcd_t          disp_q, disp_d;
    logic          held_q, held_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          expired_q, expired_d;

    bcd_t preset;
    bcd_t preset_sat;
    bcd_t cnt_stepped;
    logic cnt_all9;
    logic cnt_zero;
    logic step;
    logic start_ok;
    logic capture;

    assign preset = sw.preset_bcd;
    assign step   = running_q && (presc_q == PMAX);

    // Ripple carry/borrow through the digits for one up or down step.
    always_comb begin
        logic c;
        c           = 1'b1;
        cnt_stepped = cnt_q;
        cnt_all9    = 1'b1;
        cnt_zero    = 1'b1;
        preset_sat  = preset;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[i] != 4'd9) cnt_all9 = 1'b0;
            if (cnt_q[i] != 4'd0) cnt_zero = 1'b0;
            if (preset[i] > 4'd9) preset_sat[i] = 4'd9;
            if (c) begin
                if (down_q) begin
                    if (cnt_q[i] == 4'd0) cnt_stepped[i] = 4'd9;
                    else begin
                        cnt_stepped[i] = cnt_q[i] - 4'd1;
                        c              = 1'b0;
                    end
                end else begin
                    if (cnt_q[i] == 4'd9) cnt_stepped[i] = 4'd0;
                    else begin
                        cnt_stepped[i] = cnt_q[i] + 4'd1;
                        c              = 1'b0;
                    end
                end
            end
        end
    end

    // A down-mode start from zero would expire instantly, so it is refused.
    assign start_ok = sw.start && !running_q && !(sw.count_down && cnt_zero);
    assign capture  = sw.lap && !held_q;

    always_comb begin
        running_d = running_q;
        down_d    = down_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        expired_d = expired_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        disp_d    = disp_q;

        if (sw.clear) begin
            running_d = 1'b0;
            presc_d   = '0;
            cnt_d     = '0;
            held_d    = 1'b0;
            expired_d = 1'b0;
            disp_d    = '0;
        end else begin
            if (step) begin
                cnt_d  = cnt_stepped;
                tick_d = 1'b1;
                if (!down_q && cnt_all9) wrap_d = 1'b1;
                if (down_q && (cnt_stepped == '0)) begin
                    expired_d = 1'b1;
                    running_d = 1'b0;
                end
            end
            // Stop freezes the prescaler; the stop cycle itself still counts.
            if (running_q) presc_d = step ? '0 : presc_q + PW'(1);

            // load is only honoured while stopped, so it never meets a step.
            if (sw.load && !running_q) begin
                cnt_d     = preset_sat;
                expired_d = 1'b0;
            end else if (sw.stop) begin
                running_d = 1'b0;
            end else if (start_ok) begin
                running_d = 1'b1;
                down_d    = sw.count_down;
                expired_d = 1'b0;
            end

            if (sw.lap) held_d = !held_q;
            // Capture takes the pre-update count, so a lap on a step edge
            // holds the value shown before that step.
            disp_d = held_d ? (capture ? cnt_q : disp_q) : cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            running_q <= 1'b0;
            down_q    <= 1'b0;
            presc_q   <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            held_q    <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            running_q <= running_d;
            down_q    <= down_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            held_q    <= held_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            expired_q <= expired_d;
        end
    end

    assign sw.running     = running_q;
    assign sw.count_bcd   = cnt_q;
    assign sw.display_bcd = disp_q;
    assign sw.lap_held    = held_q;
    assign sw.tick        = tick_q;
    assign sw.wrap        = wrap_q;
    assign sw.expired     = expired_q;
endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap -- self-checking bench for stopwatch_lap (CLK_DIV=4,
// DIGITS=2). A decimal-integer reference model is stepped on every clock
// edge and compared to all outputs; a vector table and hand sequences
// check specific corner cases with fixed expected values.
module tb_stopwatch_lap;
    localparam int CD   = 4;
    localparam int D    = 2;
    localparam int MAXV = 99;

    logic clk = 1'b0;
    bit   clk_en = 1'b1;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    stopwatch_lap_if #(.DIGITS(D)) sw ();
    stopwatch_lap #(.CLK_DIV(CD), .DIGITS(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference model state: plain integers, not BCD registers.
    int m_val, m_presc, m_cap, m_disp;
    bit m_run, m_down, m_held, m_tick, m_wrap, m_exp;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int sat_val(input logic [4*D-1:0] p);
        int r;
        r = 0;
        for (int i = D - 1; i >= 0; i--) begin
            int d;
            d = int'(p[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_presc = 0; m_cap = 0; m_disp = 0;
        m_run = 0; m_down = 0; m_held = 0; m_tick = 0; m_wrap = 0; m_exp = 0;
    endtask

    // Called right after a rising edge; sw inputs still hold pre-edge values.
    task automatic model_step();
        int  cur;
        bit  run_old, stp;
        cur     = m_val;
        run_old = m_run;
        stp     = m_run && (m_presc == CD - 1);
        m_tick  = 0;
        m_wrap  = 0;
        if (sw.clear) begin
            m_val = 0; m_presc = 0; m_run = 0; m_exp = 0; m_held = 0; m_disp = 0;
            return;
        end
        if (stp) begin
            m_tick = 1;
            if (!m_down) begin
                if (m_val == MAXV) m_wrap = 1;
                m_val = (m_val + 1) % (MAXV + 1);
            end else begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_exp = 1;
                    m_run = 0;
                end
            end
        end
        if (run_old) m_presc = (m_presc + 1) % CD;
        if (sw.load && !run_old) begin
            m_val = sat_val(sw.preset_bcd);
            m_exp = 0;
        end else if (sw.stop) begin
            m_run = 0;
        end else if (sw.start && !run_old && !(sw.count_down && cur == 0)) begin
            m_run  = 1;
            m_down = sw.count_down;
            m_exp  = 0;
        end
        if (sw.lap) begin
            if (m_held) m_held = 0;
            else begin
                m_held = 1;
                m_cap  = cur;
            end
        end
        m_disp = m_held ? m_cap : m_val;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model {run,held,tick,wrap,exp,cnt,disp}",
            {11'd0, sw.running, sw.lap_held, sw.tick, sw.wrap, sw.expired,
             sw.count_bcd, sw.display_bcd},
            {11'd0, m_run, m_held, m_tick, m_wrap, m_exp,
             to_bcd(m_val), to_bcd(m_disp)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drive(input bit st, input bit sp, input bit cl, input bit ld,
                         input bit lp, input bit cdn, input logic [7:0] pre);
        sw.start = st; sw.stop = sp; sw.clear = cl; sw.load = ld; sw.lap = lp;
        sw.count_down = cdn; sw.preset_bcd = pre;
        cyc();
        sw.start = 0; sw.stop = 0; sw.clear = 0; sw.load = 0; sw.lap = 0;
    endtask

    typedef struct {
        bit         st, sp, cl, ld, lp, cdn;
        logic [7:0] pre;
        logic [7:0] e_cnt, e_disp;
        bit         e_run, e_held, e_exp;
    } vec_t;

    vec_t vt[16];
    int   ticks, wraps;

    initial begin
        // st sp cl ld lp cd pre    cnt    disp   run held exp
        vt[0]  = '{0,0,0,1,0,0,8'h98, 8'h98, 8'h98, 0,0,0};
        vt[1]  = '{0,0,0,1,0,0,8'hFA, 8'h99, 8'h99, 0,0,0};
        vt[2]  = '{0,0,0,0,1,0,8'h00, 8'h99, 8'h99, 0,1,0};
        vt[3]  = '{0,0,0,1,0,0,8'h12, 8'h12, 8'h99, 0,1,0};
        vt[4]  = '{0,0,0,0,1,0,8'h00, 8'h12, 8'h12, 0,0,0};
        vt[5]  = '{0,0,1,0,0,0,8'h00, 8'h00, 8'h00, 0,0,0};
        vt[6]  = '{1,0,0,0,0,1,8'h00, 8'h00, 8'h00, 0,0,0};
        vt[7]  = '{1,1,0,0,0,0,8'h00, 8'h00, 8'h00, 0,0,0};
        vt[8]  = '{1,0,0,1,0,0,8'h05, 8'h05, 8'h05, 0,0,0};
        vt[9]  = '{1,0,0,0,0,0,8'h00, 8'h05, 8'h05, 1,0,0};
        vt[10] = '{0,0,0,1,0,0,8'h77, 8'h05, 8'h05, 1,0,0};
        vt[11] = '{0,1,0,0,0,0,8'h00, 8'h05, 8'h05, 0,0,0};
        vt[12] = '{0,0,1,0,0,0,8'h00, 8'h00, 8'h00, 0,0,0};
        vt[13] = '{0,0,0,1,0,1,8'h01, 8'h01, 8'h01, 0,0,0};
        vt[14] = '{1,0,0,0,0,1,8'h00, 8'h01, 8'h01, 1,0,0};
        vt[15] = '{0,0,1,0,0,0,8'h00, 8'h00, 8'h00, 0,0,0};

        sw.start = 0; sw.stop = 0; sw.clear = 0; sw.load = 0; sw.lap = 0;
        sw.count_down = 0; sw.preset_bcd = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {7'd0, sw.running, sw.lap_held, sw.tick, sw.wrap, sw.expired,
             sw.count_bcd, sw.display_bcd}, 32'd0);
        reset_n = 1'b1;
        idle(3);

        // Vector table: single-cycle control operations with fixed results.
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].st, vt[i].sp, vt[i].cl, vt[i].ld, vt[i].lp, vt[i].cdn, vt[i].pre);
            chk($sformatf("vec%0d cnt", i), {24'd0, sw.count_bcd}, {24'd0, vt[i].e_cnt});
            chk($sformatf("vec%0d disp", i), {24'd0, sw.display_bcd}, {24'd0, vt[i].e_disp});
            chk($sformatf("vec%0d run/held/exp", i),
                {29'd0, sw.running, sw.lap_held, sw.expired},
                {29'd0, vt[i].e_run, vt[i].e_held, vt[i].e_exp});
        end

        // 1: up count over 40 cycles.
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        ticks = 0; wraps = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (sw.tick) ticks++;
            if (sw.wrap || sw.expired) wraps++;
        end
        chk("t1 count", {24'd0, sw.count_bcd}, 32'h10);
        chk("t1 ticks", ticks, 10);
        chk("t1 running", {31'd0, sw.running}, 32'd1);
        chk("t1 no wrap/expired", wraps, 0);

        // 2: wrap from 98.
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 1, 0, 0, 8'h98);
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (sw.wrap) wraps++;
        end
        chk("t2 count", {24'd0, sw.count_bcd}, 32'h00);
        chk("t2 wraps", wraps, 1);
        chk("t2 running", {31'd0, sw.running}, 32'd1);

        // 3: countdown to expiry.
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 1, 0, 1, 8'h03);
        drive(1, 0, 0, 0, 0, 1, 8'h00);
        idle(11);
        chk("t3 count@11", {24'd0, sw.count_bcd}, 32'h01);
        chk("t3 not expired yet", {31'd0, sw.expired}, 32'd0);
        cyc();
        chk("t3 count", {24'd0, sw.count_bcd}, 32'h00);
        chk("t3 expired/running", {30'd0, sw.expired, sw.running}, 32'b10);
        drive(1, 0, 0, 0, 0, 1, 8'h00);
        chk("t3 start ignored", {31'd0, sw.running}, 32'd0);
        drive(0, 0, 0, 1, 0, 1, 8'h05);
        chk("t3 load clears expired", {23'd0, sw.expired, sw.count_bcd}, 32'h05);

        // 4: stop/resume keeps the prescaler phase.
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (sw.tick) ticks++;
        end
        chk("t4 no ticks while stopped", ticks, 0);
        chk("t4 count frozen", {24'd0, sw.count_bcd}, 32'h00);
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        chk("t4 tick@restart", {31'd0, sw.tick}, 32'd0);
        cyc();
        chk("t4 tick@+1", {31'd0, sw.tick}, 32'd0);
        cyc();
        chk("t4 tick@+2", {23'd0, sw.tick, sw.count_bcd}, 32'h101);
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 0, 0, 8'h00);
        chk("t4 stop wins", {31'd0, sw.running}, 32'd0);

        // 5: lap hold.
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        idle(20);
        chk("t5 count 05", {24'd0, sw.count_bcd}, 32'h05);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t5 held 05", {23'd0, sw.lap_held, sw.display_bcd}, 32'h105);
        idle(15);
        chk("t5 live/held", {16'd0, sw.count_bcd, sw.display_bcd}, 32'h0905);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t5 release", {23'd0, sw.lap_held, sw.display_bcd}, 32'h009);
        idle(2);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        chk("t5 lap on tick", {15'd0, sw.tick, sw.count_bcd, sw.display_bcd}, 32'h11009);
        chk("t5 held", {31'd0, sw.lap_held}, 32'd1);
        drive(0, 0, 1, 0, 0, 0, 8'h00);
        chk("t5 clear releases", {23'd0, sw.lap_held, sw.display_bcd}, 32'h000);

        // 6: asynchronous reset with the clock stopped.
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        idle(9);
        chk("t6 pre-reset count", {24'd0, sw.count_bcd}, 32'h02);
        clk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6 async reset outputs",
            {7'd0, sw.running, sw.lap_held, sw.tick, sw.wrap, sw.expired,
             sw.count_bcd, sw.display_bcd}, 32'd0);
        model_reset();
        #4 reset_n = 1'b1;
        #3 clk_en = 1'b1;
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        idle(4);
        chk("t6 resume from 0", {24'd0, sw.count_bcd}, 32'h01);
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 1, 0, 0, 8'hFA);
        chk("t6 load FA", {24'd0, sw.count_bcd}, 32'h99);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            sw.start      = ($urandom % 6) == 0;
            sw.stop       = ($urandom % 20) == 0;
            sw.clear      = ($urandom % 80) == 0;
            sw.load       = ($urandom % 25) == 0;
            sw.lap        = ($urandom % 15) == 0;
            sw.count_down = 1'($urandom % 2);
            sw.preset_bcd = 8'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
